// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, ramp constants, FSM encoding and gain ramp helper for the output gain stage
//   DATA_W     sample width per channel (signed)
//   GAIN_W     gain fraction bits, UNITY = 2**GAIN_W
//   STEP       gain change per frame
//   UNMUTE_DLY clean frames needed before a ramp-up may start
package audio_pkg;
    localparam int DATA_W     = 32;
    localparam int GAIN_W     = 8;
    localparam int UNITY      = 2 ** GAIN_W;
    localparam int STEP       = 4;
    localparam int UNMUTE_DLY = 16;
    localparam int ACC_W      = DATA_W + GAIN_W + 1;
    localparam int CNT_W      = $clog2(UNMUTE_DLY + 1);
    localparam int IDX_W      = $clog2(GAIN_W + 1);

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    // One STEP toward 0 (up=0) or UNITY (up=1); clamping to the rail is
    // also the no-overshoot rule since the target is always a rail.
    function automatic logic [GAIN_W:0] ramp(input logic [GAIN_W:0] g, input logic up);
        int v;
        v = up ? int'(g) + STEP : int'(g) - STEP;
        v = v < 0 ? 0 : (v > UNITY ? UNITY : v);
        return (GAIN_W+1)'(v);
    endfunction
endpackage

// File: rtl/serial_mul.sv
// serial_mul: shift-add signed sample x unsigned gain multiplier, one gain bit per cycle
//   clk, rst  clock, async active-high reset
//   start     load a/b and begin; restarts (aborts) a multiply in progress
//   a         signed multiplicand
//   b         unsigned gain, GAIN_W+1 bits
//   busy      multiply in progress
//   done      high in the cycle the final partial product is added
//   p         accumulator, valid the cycle after done
module serial_mul
    import audio_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       a,
    input  logic [GAIN_W:0]         b,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] p
);
    sample_t          a_q;
    logic [GAIN_W:0]  b_q;
    logic [IDX_W-1:0] idx;

    assign done = busy && idx == IDX_W'(GAIN_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            idx  <= '0;
            p    <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            idx  <= '0;
            p    <= '0;
            a_q  <= a;
            b_q  <= b;
        end else if (busy) begin
            if (b_q[idx])
                p <= p + (ACC_W'(a_q) <<< idx);
            idx  <= idx + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/soft_mute.sv
// soft_mute: per-frame ramped gain/mute stage between the output FIFO and the I2S master
//   clk, rst             out_clk, async active-high reset
//   en                   frame strobe
//   in_left, in_right    samples from the FIFO
//   fifo_empty           FIFO empty, sampled at en
//   mute_req             host mute request (level)
//   out_left, out_right  scaled samples, one frame late
//   gain                 current gain 0..UNITY
//   muted                gain == 0
//   overrun              one-cycle pulse when en lands on a busy multiply
module soft_mute
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              fifo_empty,
    input  logic              mute_req,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic [GAIN_W:0]   gain,
    output logic              muted,
    output logic              overrun
);
    state_t                  state, state_nx;
    logic [DATA_W-1:0]       held_l, held_r, cap_l, cap_r;
    logic [CNT_W-1:0]        cnt;
    logic [GAIN_W:0]         gain_nx;
    logic                    up, wr;
    logic                    busy_l, busy_r, done_l, done_r;
    logic signed [ACC_W-1:0] p_l, p_r;

    // An empty FIFO keeps the last good sample so fade-outs never touch garbage.
    assign cap_l   = fifo_empty ? held_l : in_left;
    assign cap_r   = fifo_empty ? held_r : in_right;
    // Uses the counter value before this frame's update: the first ramp-up
    // happens on the frame after UNMUTE_DLY clean frames.
    assign up      = !(mute_req || fifo_empty || cnt < CNT_W'(UNMUTE_DLY));
    assign gain_nx = ramp(gain, up);
    assign muted   = gain == '0;

    serial_mul u_mul_l (
        .clk(clk), .rst(rst), .start(en), .a(cap_l), .b(gain_nx),
        .busy(busy_l), .done(done_l), .p(p_l)
    );

    serial_mul u_mul_r (
        .clk(clk), .rst(rst), .start(en), .a(cap_r), .b(gain_nx),
        .busy(busy_r), .done(done_r), .p(p_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // en from any state restarts; a DONE hit by en never writes its result.
    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        if (en)
            state_nx = MUL;
        else if (state == MUL)
            state_nx = done_l && done_r ? DONE : MUL;
        else if (state == DONE) begin
            state_nx = IDLE;
            wr       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_l    <= '0;
            held_r    <= '0;
            cnt       <= '0;
            gain      <= '0;
            out_left  <= '0;
            out_right <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= en && (busy_l || busy_r || state == DONE);
            if (en) begin
                held_l <= cap_l;
                held_r <= cap_r;
                gain   <= gain_nx;
                cnt    <= fifo_empty ? '0 : (cnt == CNT_W'(UNMUTE_DLY) ? cnt : cnt + 1'b1);
            end
            if (wr) begin
                out_left  <= DATA_W'(p_l >>> GAIN_W);
                out_right <= DATA_W'(p_r >>> GAIN_W);
            end
        end
    end
endmodule

// File: tb/tb_soft_mute.sv
// tb_soft_mute: directed scenarios plus randomized frames checked every cycle against a frame-level model
module tb_soft_mute;
    logic        clk = 1'b0;
    logic        rst;
    logic        en = 1'b0;
    logic [31:0] in_left = '0, in_right = '0;
    logic        fifo_empty = 1'b0, mute_req = 1'b0;
    logic [31:0] out_left, out_right;
    logic [8:0]  gain;
    logic        muted, overrun;

    int n_chk = 0;
    int n_fail = 0;

    soft_mute dut (
        .clk(clk), .rst(rst), .en(en), .in_left(in_left), .in_right(in_right),
        .fifo_empty(fifo_empty), .mute_req(mute_req), .out_left(out_left),
        .out_right(out_right), .gain(gain), .muted(muted), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Frame-level model: gain walks 4 per frame toward 0 or 256, the
    // product appears 10 clocks after the strobe unless a new strobe comes first.
    int          m_gain, m_cnt, m_pend;
    logic [31:0] m_held_l, m_held_r, m_res_l, m_res_r, m_out_l, m_out_r;
    logic        m_ovr;

    function automatic int next_gain(input int g, input int c, input logic mr, input logic fe);
        int t;
        t = (mr || fe || c < 16) ? 0 : 256;
        return g < t ? (g + 4 > t ? t : g + 4) : (g - 4 < t ? t : g - 4);
    endfunction

    function automatic logic [31:0] scale(input logic [31:0] s, input int g);
        longint p;
        p = longint'($signed(s)) * g;
        return 32'(p >>> 8);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gain <= 0; m_cnt <= 0; m_pend <= 0; m_ovr <= 1'b0;
            m_held_l <= '0; m_held_r <= '0; m_res_l <= '0; m_res_r <= '0;
            m_out_l <= '0; m_out_r <= '0;
        end else if (en) begin
            m_held_l <= fifo_empty ? m_held_l : in_left;
            m_held_r <= fifo_empty ? m_held_r : in_right;
            m_gain   <= next_gain(m_gain, m_cnt, mute_req, fifo_empty);
            m_res_l  <= scale(fifo_empty ? m_held_l : in_left, next_gain(m_gain, m_cnt, mute_req, fifo_empty));
            m_res_r  <= scale(fifo_empty ? m_held_r : in_right, next_gain(m_gain, m_cnt, mute_req, fifo_empty));
            m_cnt    <= fifo_empty ? 0 : (m_cnt < 16 ? m_cnt + 1 : 16);
            m_ovr    <= m_pend > 0;
            m_pend   <= 10;
        end else begin
            m_ovr <= 1'b0;
            if (m_pend > 0) m_pend <= m_pend - 1;
            if (m_pend == 1) begin
                m_out_l <= m_res_l;
                m_out_r <= m_res_r;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("gain", 64'(gain), 64'(m_gain));
            check("muted", 64'(muted), 64'(m_gain == 0));
            check("overrun", 64'(overrun), 64'(m_ovr));
            check("out_left", 64'(out_left), 64'(m_out_l));
            check("out_right", 64'(out_right), 64'(m_out_r));
        end
    end

    task automatic frame(input int gap);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    logic [31:0] saved;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_gain", 64'(gain), 64'd0);
        check("reset_muted", 64'(muted), 64'd1);
        check("reset_out", 64'({out_left, out_right}), 64'd0);
        rst = 1'b0;

        // Fade-in after reset
        in_left = 32'h12345678;
        in_right = 32'hFEDCBA98;
        repeat (16) frame(12);
        check("s1_gain_hold", 64'(gain), 64'd0);
        frame(12);
        check("s1_gain_first", 64'(gain), 64'd4);
        check("s1_out_left", 64'(out_left), 64'h48D159);
        repeat (3) frame(12);
        check("s1_gain_20", 64'(gain), 64'd16);

        // Unity passthrough at the extremes
        in_left = 32'h80000000;
        in_right = 32'h7FFFFFFF;
        repeat (61) frame(12);
        check("s2_gain", 64'(gain), 64'd256);
        check("s2_out_left", 64'(out_left), 64'h80000000);
        check("s2_out_right", 64'(out_right), 64'h7FFFFFFF);
        check("s2_muted", 64'(muted), 64'd0);

        // Host mute ramp-down
        mute_req = 1'b1;
        in_right = -32'sd4096;
        repeat (32) frame(12);
        check("s3_gain_half", 64'(gain), 64'd128);
        check("s3_out_right", 64'(out_right), 64'hFFFFF800);
        repeat (32) frame(12);
        check("s3_gain_zero", 64'(gain), 64'd0);
        check("s3_muted", 64'(muted), 64'd1);
        mute_req = 1'b0;

        // Underrun: fade on the last good sample
        repeat (65) frame(12);
        in_left = 32'h00010000;
        frame(12);
        fifo_empty = 1'b1;
        repeat (3) begin
            in_left = $urandom;
            frame(12);
        end
        check("s4_gain", 64'(gain), 64'd244);
        check("s4_out_left", 64'(out_left), 64'hF400);
        fifo_empty = 1'b0;
        repeat (16) frame(12);
        check("s4_gain_wait", 64'(gain), 64'd180);
        frame(12);
        check("s4_gain_resume", 64'(gain), 64'd184);

        // Strobe during a multiply
        saved = out_left;
        in_left = 32'h7000;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        in_left = 32'h100;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("s5_overrun", 64'(overrun), 64'd1);
        check("s5_out_hold", 64'(out_left), 64'(saved));
        repeat (12) @(negedge clk);
        check("s5_gain", 64'(gain), 64'd192);
        check("s5_out_left", 64'(out_left), 64'hC0);

        // Reset in the middle of a multiply
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("s6_out", 64'({out_left, out_right}), 64'd0);
        check("s6_gain", 64'(gain), 64'd0);
        check("s6_muted", 64'(muted), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        in_left = 32'h12345678;
        repeat (16) frame(12);
        check("s6_gain_hold", 64'(gain), 64'd0);
        frame(12);
        check("s6_gain_first", 64'(gain), 64'd4);

        // Randomized frames, spacing and control
        repeat (300) begin
            in_left = $urandom;
            in_right = $urandom;
            fifo_empty = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 39) == 0) mute_req = !mute_req;
            frame($urandom_range(0, 9) == 0 ? $urandom_range(3, 10) : $urandom_range(11, 20));
        end
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/soft_mute.md
Name: soft_mute

Overview:
- Gain/mute stage between trans_buffer and i2s_master in the out_clk domain.
- Applies a per-frame ramped gain to both channels: fades in after reset, fades out on SPI mute request or FIFO underrun, fades back in once data flow is stable.
- Removes clicks when the output FIFO runs dry or the host mutes the stream.

Parameters:
- DATA_W, 32, sample width per channel, signed two's complement.
- GAIN_W, 8, gain fraction bits; unity gain UNITY = 2**GAIN_W = 256.
- STEP, 4, gain increment/decrement applied per frame.
- UNMUTE_DLY, 16, consecutive non-empty frames required before a ramp-up may start.

Ports:
- clk  in  1  out_clk, the I2S output bit-rate clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  one-cycle frame strobe from i2s_master; same strobe that trans_buffer uses.
- in_left  in  DATA_W  left sample from trans_buffer.
- in_right  in  DATA_W  right sample from trans_buffer.
- fifo_empty  in  1  FIFO rdempty, sampled at en.
- mute_req  in  1  host mute request, level, already synchronous to clk.
- out_left  out  DATA_W  scaled left sample to i2s_master.
- out_right  out  DATA_W  scaled right sample to i2s_master.
- gain  out  GAIN_W+1  current gain, range 0..UNITY.
- muted  out  1  high when gain == 0.
- overrun  out  1  one-cycle pulse when en arrives while a multiply is in progress.

Behaviour:
- Reset (async, rst=1): out_left, out_right = 0; gain = 0; muted = 1; overrun = 0; stable-frame counter = 0; state = IDLE; held samples = 0.
- Sample capture at en:
  - If fifo_empty = 0: latch in_left/in_right into the held registers.
  - If fifo_empty = 1: keep the previous held samples, so the fade-out runs on the last good sample, never stale or garbage data.
- Stable counter:
  - At each en: fifo_empty = 1 clears it to 0; otherwise it increments, saturating at UNMUTE_DLY.
- Gain target:
  - 0 if mute_req = 1, or fifo_empty = 1 at this en, or stable counter < UNMUTE_DLY.
  - UNITY otherwise.
- Gain update:
  - At each en, before the multiply starts, gain moves STEP toward the target.
  - Saturating: never below 0, never above UNITY, and never overshoots the target.
  - The multiply uses the updated gain.
- FSM: IDLE -> MUL -> DONE -> IDLE.
  - IDLE: on en, capture samples and update gain; go to MUL with bit index 0 and accumulators 0.
  - MUL: shift-add over gain bits 0..GAIN_W (GAIN_W+1 cycles). Each cycle, if gain[i]=1, add the held sample sign-extended and shifted left by i to that channel's accumulator (DATA_W+GAIN_W+1 bits). Both channels run in parallel.
  - DONE: out_x = accumulator arithmetic-shifted right by GAIN_W, truncated to DATA_W; then go to IDLE.
- Exactness: gain = UNITY gives exact passthrough; gain = 0 gives exact 0.
- Latency: outputs are valid GAIN_W+3 cycles after en and stay stable until the next result. i2s_master latches them at the following en, so samples appear one frame late.
- en spacing: at least GAIN_W+3 cycles is required. A frame at out_clk is ≥ 64 cycles, so normal operation always satisfies this.
- en while in MUL or DONE:
  - The current computation is abandoned and out_x keep their previous values.
  - overrun pulses for 1 cycle.
  - A new capture, gain update and MUL start immediately.
- mute_req toggling mid-ramp: the gain reverses direction at the next en, with no jump.
- rst asserted mid-MUL: all state is cleared immediately (async); the block restarts muted and fades in again.

Decomposition:
- Shared package, audio_pkg: DATA_W, GAIN_W, UNITY, the FSM state encoding, and the sample typedef.
- One natural sub-module: serial_mul, a shift-add signed × unsigned multiplier. It is instantiated once per channel, with start/busy/done handshake and abort-on-start.

Test Plan:
1. Reset, then feed 20 frames with fifo_empty=0 and in_left=0x12345678 → gain stays 0 for frames 1–16, then rises 4, 8, 12, …; out_left = (0x12345678*gain)>>>8. Check both channels.
2. Run until gain = 256 with in_left=0x80000000, in_right=0x7FFFFFFF → outputs exactly equal inputs one frame later; muted = 0.
3. At gain 256, assert mute_req → gain goes 252, 248, … to 0 in 64 frames; out_right for in_right=-4096 at gain 128 is -2048; muted = 1 at the end.
4. Underrun: fifo_empty=1 for 3 frames at gain 256 with the last good sample 0x00010000 → ramp-down uses 0x00010000 (not in_left); gain reaches 244 after 3 frames; ramp-up resumes only after 16 clean frames.
5. en pulses 5 cycles apart → overrun pulses once; out_x unchanged from the prior result; the second computation completes correctly.
6. Assert rst mid-MUL → all outputs 0 and gain 0 the same cycle; after release, the fade-in sequence repeats as in scenario 1.
